// File: rtl/snitch_acc_scoreboard.sv
// Request-side hazard scoreboard between the Snitch core and the FP subsystem.
// Optional RAW source-register check enabled by defining SNITCH_ACC_SB_RS_CHECK_EN.

package snitch_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [4:0]  id;
      logic [31:0] data_op;
      logic [63:0] data_arga;
      logic [63:0] data_argb;
      logic [63:0] data_argc;
   } acc_req_t;

   typedef struct packed {
      logic [4:0]  id;
      logic        error;
      logic [63:0] data;
   } acc_resp_t;

endpackage

module snitch_acc_scoreboard #(
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  snitch_pkg::acc_req_t acc_req_i,
   input  logic                 acc_req_valid_i,
   output logic                 acc_req_ready_o,
   output snitch_pkg::acc_req_t acc_req_o,
   output logic                 acc_req_valid_o,
   input  logic                 acc_req_ready_i,
   input  snitch_pkg::acc_resp_t acc_resp_i,
   input  logic                 acc_resp_valid_i,
   output logic                 acc_resp_ready_o,
   output snitch_pkg::acc_resp_t acc_resp_o,
   output logic                 acc_resp_valid_o,
   input  logic                 acc_resp_ready_i,
   output logic                 idle_o,
   output logic                 err_o
);

   // Handshake rule on both paths: a transfer happens in a cycle where valid
   // and ready are both high; valid, once raised, stays high and stable until
   // that transfer. Requests are gated by hazard; responses pass through as-is.

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
   localparam logic [CntW-1:0] OneCnt = CntW'(1);

   logic [31:0]     pending_q, pending_d;
   logic [CntW-1:0] count_q, count_d;
   logic            err_q, err_d;

   logic [4:0] rd;
   logic       hazard;
   logic       cap_full;
   logic       req_hs;
   logic       resp_hs;

   assign rd       = acc_req_i.data_op[11:7];
   assign cap_full = (count_q == MaxCnt);

`ifdef SNITCH_ACC_SB_RS_CHECK_EN
   logic [4:0] rs1, rs2, rs3;
   assign rs1 = acc_req_i.data_op[19:15];
   assign rs2 = acc_req_i.data_op[24:20];
   assign rs3 = acc_req_i.data_op[31:27];
   // Source registers still being written also stall issue (RAW chains).
   assign hazard = pending_q[rd] | cap_full
                 | pending_q[rs1] | pending_q[rs2] | pending_q[rs3];
`else
   assign hazard = pending_q[rd] | cap_full;
`endif

   assign acc_req_o        = acc_req_i;
   assign acc_req_valid_o  = acc_req_valid_i & ~hazard;
   assign acc_req_ready_o  = acc_req_ready_i & ~hazard;
   assign req_hs           = acc_req_valid_i & acc_req_ready_o;

   assign acc_resp_o       = acc_resp_i;
   assign acc_resp_valid_o = acc_resp_valid_i;
   assign acc_resp_ready_o = acc_resp_ready_i;
   assign resp_hs          = acc_resp_valid_i & acc_resp_ready_i;

   always_comb begin
      pending_d = pending_q;
      err_d     = err_q;
      // Clear first, then set: hazard on registered state keeps the two
      // from ever targeting a legitimately pending ID in the same cycle.
      if (resp_hs) begin
         if (!pending_q[acc_resp_i.id]) err_d = 1'b1;
         pending_d[acc_resp_i.id] = 1'b0;
      end
      if (req_hs) begin
         pending_d[rd] = 1'b1;
      end
   end

   always_comb begin
      count_d = count_q;
      unique case ({req_hs, resp_hs})
         2'b10: count_d = count_q + OneCnt;
         2'b01: begin
            if (count_q == '0) begin
               count_d = '0;
            end else begin
               count_d = count_q - OneCnt;
            end
         end
         default: count_d = count_q;
      endcase
   end

   logic underflow;
   assign underflow = resp_hs & ~req_hs & (count_q == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending_q <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         count_q   <= count_d;
         err_q     <= err_d | underflow;
      end
   end

   assign idle_o = (count_q == '0);
   assign err_o  = err_q;

endmodule
